// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
// Cell codes, controller states and the winning-line index table.
package ttt_pkg;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] PX    = 2'b01;
  localparam logic [1:0] PO    = 2'b10;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned NUM_LINES = 8;

  typedef enum logic [1:0] {
    StWait = 2'b00,
    StScan = 2'b01,
    StDone = 2'b10
  } state_e;

  // Rows, columns, then the two diagonals; scan order matters for the latched winner.
  localparam logic [3:0] LINE_TBL [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == PX) ? PO : PX;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational three-cell line checker: a line wins when it is occupied
// and all three cells hold the same player code.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [1:0] cell_a,
  input  logic [1:0] cell_b,
  input  logic [1:0] cell_c,
  output logic       win,
  output logic [1:0] code
);

  always_comb begin
    win  = (cell_a != EMPTY) && (cell_a == cell_b) && (cell_b == cell_c);
    code = win ? cell_a : EMPTY;
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: board register, move handshake, and a
// one-line-per-clock scan over the 8 winning lines after every move.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER = PX,
  parameter bit         EARLY_EXIT   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        move_valid,
  input  logic [3:0]  move_pos,
  output logic        move_ready,
  output logic        illegal,
  output logic [17:0] board,
  output logic [1:0]  turn,
  output logic [3:0]  move_count,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        draw
);

  state_e      state_q, state_d;
  logic [17:0] board_q, board_d;
  logic [1:0]  turn_q, turn_d;
  logic [3:0]  move_count_q, move_count_d;
  logic [2:0]  line_idx_q, line_idx_d;
  logic        illegal_q, illegal_d;
  logic [1:0]  winner_q, winner_d;
  logic        draw_q, draw_d;
  logic        win_found_q, win_found_d;
  logic [1:0]  win_code_q, win_code_d;

  logic [1:0]  cells [NUM_CELLS];
  logic        pos_ok, try_move, accept, reject;
  logic [1:0]  target;
  logic        scan, last, line_win;
  logic [1:0]  line_code;
  logic        first_found;
  logic [1:0]  first_code;
  logic        end_win, end_draw, to_wait;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
      cells[i] = board_q[2*i +: 2];
    end
  end

  always_comb begin
    pos_ok   = move_pos < 4'd9;
    target   = pos_ok ? cells[move_pos] : EMPTY;
    try_move = (state_q == StWait) && move_valid && !new_game;
    accept   = try_move && pos_ok && (target == EMPTY);
    reject   = try_move && !accept;
  end

  ttt_line_check u_line_check (
    .cell_a (cells[LINE_TBL[line_idx_q][0]]),
    .cell_b (cells[LINE_TBL[line_idx_q][1]]),
    .cell_c (cells[LINE_TBL[line_idx_q][2]]),
    .win    (line_win),
    .code   (line_code)
  );

  // Scan outcome; the earliest winning line in scan order owns the result.
  always_comb begin
    scan        = (state_q == StScan);
    last        = (line_idx_q == 3'd7);
    first_found = win_found_q || line_win;
    first_code  = win_found_q ? win_code_q : line_code;
    end_win     = scan && ((EARLY_EXIT && line_win) || (last && first_found));
    end_draw    = scan && last && !first_found && (move_count_q == 4'd9);
    to_wait     = scan && last && !first_found && (move_count_q != 4'd9);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StWait;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait: if (accept) state_d = StScan;
      StScan: begin
        if (end_win || end_draw) begin
          state_d = StDone;
        end else if (to_wait) begin
          state_d = StWait;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StWait;
    endcase
    if (new_game) state_d = StWait;
  end

  // Output decode
  always_comb begin
    move_ready = (state_q == StWait);
    game_over  = (state_q == StDone);
  end

  always_comb begin
    board_d      = board_q;
    turn_d       = turn_q;
    move_count_d = move_count_q;
    line_idx_d   = line_idx_q;
    illegal_d    = reject;
    winner_d     = winner_q;
    draw_d       = draw_q;
    win_found_d  = win_found_q;
    win_code_d   = win_code_q;

    if (accept) begin
      for (int unsigned i = 0; i < NUM_CELLS; i++) begin
        if (move_pos == 4'(i)) board_d[2*i +: 2] = turn_q;
      end
      move_count_d = move_count_q + 4'd1;
      line_idx_d   = 3'd0;
      win_found_d  = 1'b0;
      win_code_d   = EMPTY;
    end

    if (scan) begin
      line_idx_d = line_idx_q + 3'd1;
      if (line_win && !win_found_q) begin
        win_found_d = 1'b1;
        win_code_d  = line_code;
      end
      if (end_win)  winner_d = first_code;
      if (end_draw) draw_d   = 1'b1;
      if (to_wait)  turn_d   = other_player(turn_q);
    end

    if (new_game) begin
      board_d      = '0;
      turn_d       = FIRST_PLAYER;
      move_count_d = '0;
      line_idx_d   = '0;
      illegal_d    = 1'b0;
      winner_d     = EMPTY;
      draw_d       = 1'b0;
      win_found_d  = 1'b0;
      win_code_d   = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board_q      <= '0;
      turn_q       <= FIRST_PLAYER;
      move_count_q <= '0;
      line_idx_q   <= '0;
      illegal_q    <= 1'b0;
      winner_q     <= EMPTY;
      draw_q       <= 1'b0;
      win_found_q  <= 1'b0;
      win_code_q   <= EMPTY;
    end else begin
      board_q      <= board_d;
      turn_q       <= turn_d;
      move_count_q <= move_count_d;
      line_idx_q   <= line_idx_d;
      illegal_q    <= illegal_d;
      winner_q     <= winner_d;
      draw_q       <= draw_d;
      win_found_q  <= win_found_d;
      win_code_q   <= win_code_d;
    end
  end

  assign board      = board_q;
  assign turn       = turn_q;
  assign move_count = move_count_q;
  assign illegal    = illegal_q;
  assign winner     = winner_q;
  assign draw       = draw_q;

endmodule
